// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer that borrows the core's shared ALU
// for one ADD/SUB per iteration (shift-add multiply, restoring divide).
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            alu_own,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_rd,
    input  logic [3:0]      alu_flags
);
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;   // hi/lo double as rem/quo
    logic [XLEN-1:0]  mc_q, mc_d;               // multiplicand or divisor
    logic [XLEN-1:0]  res_q, res_d;
    logic             sa_q, sa_d, sb_q, sb_d;

    logic              is_div, is_rem, sa_w, sb_w, ovf_w, carry;
    logic [XLEN-1:0]   abs_a, abs_b, t_w;
    logic [2*XLEN-1:0] prod_fix;
    logic              unused_flags;

    assign is_div = op_q[2];
    assign is_rem = op_q[1];
    assign sa_w   = a_q[XLEN-1] & (op_q inside {3'b001, 3'b010, 3'b100, 3'b110});
    assign sb_w   = b_q[XLEN-1] & (op_q inside {3'b001, 3'b100, 3'b110});
    assign abs_a  = sa_w ? -a_q : a_q;
    assign abs_b  = sb_w ? -b_q : b_q;
    assign ovf_w  = is_div & ~op_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == '1);
    assign carry  = alu_flags[1];
    assign t_w    = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mc_d     = mc_q;
        res_d    = res_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        alu_own  = 1'b0;
        alu_ctrl = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        prod_fix = {hi_q, lo_q};
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                sa_d    = sa_w;
                sb_d    = sb_w;
                mc_d    = abs_b;
                cnt_d   = '0;
                hi_d    = '0;
                lo_d    = abs_a;
                state_d = S_ITER;
                // Divide corner cases bypass the iteration entirely
                if (is_div && b_q == '0) begin
                    res_d   = is_rem ? a_q : '1;
                    state_d = S_DONE;
                end else if (ovf_w) begin
                    res_d   = is_rem ? '0 : a_q;
                    state_d = S_DONE;
                end
            end
            S_ITER: begin
                alu_own = 1'b1;
                if (!is_div) begin
                    alu_a = hi_q;
                    alu_b = mc_q;
                    if (lo_q[0]) {hi_d, lo_d} = {carry, alu_rd, lo_q[XLEN-1:1]};
                    else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
                end else begin
                    alu_ctrl = ALU_SUB;
                    alu_a    = t_w;
                    alu_b    = mc_q;
                    // 33-bit {top,t} >= divisor: either top set or no borrow
                    if (hi_q[XLEN-1] | ~carry) begin
                        hi_d = alu_rd;
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = t_w;
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div) begin
                    if (sa_q ^ sb_q) prod_fix = -{hi_q, lo_q};
                    res_d = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                end else if (is_rem) begin
                    res_d = sa_q ? -hi_q : hi_q;
                end else begin
                    res_d = (sa_q ^ sb_q) ? -lo_q : lo_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mc_q    <= '0;
            res_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mc_q    <= mc_d;
            res_q   <= res_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: models the shared core ALU, checks directed RV32M cases
// and random ops against a plain-arithmetic reference, plus latency/backpressure/reset.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, alu_own;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b, out_result, alu_a, alu_b, alu_rd;
    logic [3:0]  alu_ctrl, alu_flags;
    logic [32:0] alu_sum;

    int vectors = 0;
    int miscompares = 0;

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .alu_own(alu_own), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_rd(alu_rd), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    // Core ALU: carry is carry-out of ADD, borrow of SUB
    always_comb begin
        if (alu_ctrl == 4'b1000) alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
        else                     alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_rd    = alu_sum[31:0];
    assign alu_flags = {alu_sum[31], alu_sum[31:0] == 32'h0, alu_sum[32], 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] as64, bs64, bu64s;
        logic [63:0]        p;
        logic signed [31:0] sa, sb, q;
        as64  = {{32{a[31]}}, a};
        bs64  = {{32{b[31]}}, b};
        bu64s = {32'h0, b};
        sa = a;
        sb = b;
        case (op)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = as64 * bs64;             return p[63:32]; end
            3'd2: begin p = as64 * bu64s;            return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                q = sa / sb; return q;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = sa % sb; return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one request and follow it to DONE; handshakes it if out_ready is high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input string tag);
        int lat, own;
        bit bad, spec;
        spec = op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
        lat = 1; own = 0; bad = 0;
        while (!out_valid && lat < 200) begin
            if (alu_own) begin
                own++;
                if (alu_ctrl !== (op[2] ? 4'b1000 : 4'b0000)) bad = 1;
            end else if (alu_ctrl !== 4'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
                bad = 1;
            end
            @(posedge clk); #1; lat++;
        end
        chk({tag, " latency"}, 32'(lat), spec ? 32'd2 : 32'd35);
        chk({tag, " alu_own_cycles"}, 32'(own), spec ? 32'd0 : 32'd32);
        chk({tag, " alu_bus"}, 32'(bad), 32'd0);
        chk({tag, " result"}, out_result, exp_res);
        chk({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
            chk({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " out_result"}, out_result, 32'h0);
        chk({tag, " alu_own"}, 32'(alu_own), 32'd0);
        chk({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'd0);
        chk({tag, " alu_a"}, alu_a, 32'h0);
        chk({tag, " alu_b"}, alu_b, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 32'h0; in_b = 32'h0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("reset");

        run_op(3'd0, 32'd7, 32'd6, 32'd42, "mul_7x6");
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu_m1x2");
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7");
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0");
        run_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_by0");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf");

        // Backpressure in DONE
        out_ready = 1'b0;
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold out_result", out_result, 32'd14);
            chk("bp_hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release out_valid", 32'(out_valid), 32'd0);
        chk("bp_release in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of ITER (counter at 10)
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'd123; in_b = 32'd456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) begin @(posedge clk); #1; end
        chk("midreset alu_own_before", 32'(alu_own), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("midreset");
        run_op(3'd0, 32'd3, 32'd5, 32'd15, "mul_after_reset");

        // Random ops against the arithmetic reference
        for (int i = 0; i < 32; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                default: ;
            endcase
            run_op(op, a, b, ref_model(op, a, b), $sformatf("rand%0d_op%0d", i, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
